// File: rtl/bp_axi4_mem_responder.sv
// bp_axi4_mem_responder: AXI4 subordinate backed by an internal word-addressed
// memory. Serves one transaction at a time (write burst or read burst), INCR
// bursts up to 256 beats at full bus width.
// Build option: define BP_AXI4_MEM_RESPONDER_WRAP_EN to accept WRAP bursts
// (len 1/3/7/15); without it every non-INCR burst is answered with SLVERR.
module bp_axi4_mem_responder #(
  parameter int axi_addr_width_p = 64,
  parameter int axi_data_width_p = 64,
  parameter int axi_id_width_p   = 1,
  localparam int axi_strb_width_lp = axi_data_width_p / 8,
  parameter int mem_els_p        = 1024,
  parameter logic [axi_addr_width_p-1:0] base_addr_p = '0
) (
  input  logic                          clk_i,
  input  logic                          reset_n_i,
  // write address
  input  logic [axi_id_width_p-1:0]     s_axi_awid_i,
  input  logic [axi_addr_width_p-1:0]   s_axi_awaddr_i,
  input  logic [7:0]                    s_axi_awlen_i,
  input  logic [2:0]                    s_axi_awsize_i,
  input  logic [1:0]                    s_axi_awburst_i,
  input  logic [3:0]                    s_axi_awcache_i,
  input  logic [2:0]                    s_axi_awprot_i,
  input  logic [3:0]                    s_axi_awqos_i,
  input  logic                          s_axi_awvalid_i,
  output logic                          s_axi_awready_o,
  // write data
  input  logic [axi_id_width_p-1:0]     s_axi_wid_i,
  input  logic [axi_data_width_p-1:0]   s_axi_wdata_i,
  input  logic [axi_strb_width_lp-1:0]  s_axi_wstrb_i,
  input  logic                          s_axi_wlast_i,
  input  logic                          s_axi_wvalid_i,
  output logic                          s_axi_wready_o,
  // write response
  output logic [axi_id_width_p-1:0]     s_axi_bid_o,
  output logic [1:0]                    s_axi_bresp_o,
  output logic                          s_axi_bvalid_o,
  input  logic                          s_axi_bready_i,
  // read address
  input  logic [axi_id_width_p-1:0]     s_axi_arid_i,
  input  logic [axi_addr_width_p-1:0]   s_axi_araddr_i,
  input  logic [7:0]                    s_axi_arlen_i,
  input  logic [2:0]                    s_axi_arsize_i,
  input  logic [1:0]                    s_axi_arburst_i,
  input  logic [3:0]                    s_axi_arcache_i,
  input  logic [2:0]                    s_axi_arprot_i,
  input  logic [3:0]                    s_axi_arqos_i,
  input  logic                          s_axi_arvalid_i,
  output logic                          s_axi_arready_o,
  // read data
  output logic [axi_id_width_p-1:0]     s_axi_rid_o,
  output logic [axi_data_width_p-1:0]   s_axi_rdata_o,
  output logic [1:0]                    s_axi_rresp_o,
  output logic                          s_axi_rlast_o,
  output logic                          s_axi_rvalid_o,
  input  logic                          s_axi_rready_i
);

  localparam int lg_strb_lp = $clog2(axi_strb_width_lp);
  localparam int idx_w_lp   = $clog2(mem_els_p);
  localparam logic [axi_addr_width_p-1:0] mem_els_a_lp = axi_addr_width_p'(mem_els_p);

  typedef enum logic [1:0] {IDLE, WDATA, WRESP, RDATA} state_e;

  state_e                      r_state;
  logic                        r_pri_rd;   // on a tie, grant read when set
  logic                        r_err;
  logic                        r_wrap;
  logic [axi_id_width_p-1:0]   r_id;
  logic [7:0]                  r_len;
  logic [7:0]                  r_cnt;
  logic [idx_w_lp-1:0]         r_idx;
  logic [axi_data_width_p-1:0] r_mem [mem_els_p];

  // Arbitration: a lone request wins; a tie goes to the side not served last.
  logic w_gnt_aw, w_gnt_ar;
  assign w_gnt_aw = s_axi_awvalid_i & (~s_axi_arvalid_i | ~r_pri_rd);
  assign w_gnt_ar = s_axi_arvalid_i & (~s_axi_awvalid_i |  r_pri_rd);

  // The granted channel's payload feeds one shared decode path.
  logic [axi_addr_width_p-1:0] w_addr, w_word, w_len_a, w_first, w_endw;
  logic [axi_id_width_p-1:0]   w_id;
  logic [7:0]                  w_len;
  logic [2:0]                  w_size;
  logic [1:0]                  w_burst;
  logic                        w_wrap_ok, w_req_err;

  assign w_addr  = w_gnt_aw ? s_axi_awaddr_i  : s_axi_araddr_i;
  assign w_id    = w_gnt_aw ? s_axi_awid_i    : s_axi_arid_i;
  assign w_len   = w_gnt_aw ? s_axi_awlen_i   : s_axi_arlen_i;
  assign w_size  = w_gnt_aw ? s_axi_awsize_i  : s_axi_arsize_i;
  assign w_burst = w_gnt_aw ? s_axi_awburst_i : s_axi_arburst_i;

  // An address below the base wraps to a huge word index and fails the range test.
  assign w_word  = (w_addr - base_addr_p) >> lg_strb_lp;
  assign w_len_a = axi_addr_width_p'(w_len);

`ifdef BP_AXI4_MEM_RESPONDER_WRAP_EN
  assign w_wrap_ok = (w_burst == 2'b10) &&
                     ((w_len == 8'd1) || (w_len == 8'd3) || (w_len == 8'd7) || (w_len == 8'd15));
`else
  assign w_wrap_ok = 1'b0;
`endif

  // Range check covers the whole burst: the wrap window or start..start+len.
  assign w_first   = w_wrap_ok ? (w_word & ~w_len_a) : w_word;
  assign w_endw    = w_first + w_len_a;
  assign w_req_err = (w_size != 3'(lg_strb_lp)) ||
                     !((w_burst == 2'b01) || w_wrap_ok) ||
                     (w_endw >= mem_els_a_lp);

  // Next beat index: plain increment, or increment inside the wrap window.
  logic [idx_w_lp-1:0] w_idx_inc, w_mask, w_idx_nxt;
  assign w_idx_inc = r_idx + 1'b1;
  assign w_mask    = idx_w_lp'(r_len);
  assign w_idx_nxt = r_wrap ? ((r_idx & ~w_mask) | (w_idx_inc & w_mask)) : w_idx_inc;

  logic w_last_beat, w_w_hs, w_wlast_bad, w_mem_we;
  assign w_last_beat = (r_cnt == r_len);
  assign w_w_hs      = s_axi_wready_o & s_axi_wvalid_i;
  assign w_wlast_bad = s_axi_wlast_i != w_last_beat;
  // A beat carrying a misplaced wlast is itself not written.
  assign w_mem_we    = w_w_hs & ~r_err & ~w_wlast_bad & reset_n_i;

  assign s_axi_awready_o = reset_n_i & (r_state == IDLE) & w_gnt_aw;
  assign s_axi_arready_o = reset_n_i & (r_state == IDLE) & w_gnt_ar;
  assign s_axi_wready_o  = (r_state == WDATA);
  assign s_axi_bvalid_o  = (r_state == WRESP);
  assign s_axi_bid_o     = s_axi_bvalid_o ? r_id : '0;
  assign s_axi_bresp_o   = (s_axi_bvalid_o & r_err) ? 2'b10 : 2'b00;
  assign s_axi_rvalid_o  = (r_state == RDATA);
  assign s_axi_rid_o     = s_axi_rvalid_o ? r_id : '0;
  assign s_axi_rresp_o   = (s_axi_rvalid_o & r_err) ? 2'b10 : 2'b00;
  assign s_axi_rlast_o   = s_axi_rvalid_o & w_last_beat;
  assign s_axi_rdata_o   = (s_axi_rvalid_o & ~r_err) ? r_mem[r_idx] : '0;

  // Byte-enabled write port; contents survive reset.
  always_ff @(posedge clk_i) begin
    if (w_mem_we)
      for (int b = 0; b < axi_strb_width_lp; b++)
        if (s_axi_wstrb_i[b]) r_mem[r_idx][8*b +: 8] <= s_axi_wdata_i[8*b +: 8];
  end

  // Transaction FSM: latch request, walk beats, return response.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      r_state  <= IDLE;
      r_pri_rd <= 1'b1;
      r_err    <= 1'b0;
      r_wrap   <= 1'b0;
      r_id     <= '0;
      r_len    <= '0;
      r_cnt    <= '0;
      r_idx    <= '0;
    end else begin
      case (r_state)
        IDLE: if (w_gnt_aw | w_gnt_ar) begin
          r_state  <= w_gnt_aw ? WDATA : RDATA;
          r_pri_rd <= w_gnt_aw;
          r_id     <= w_id;
          r_len    <= w_len;
          r_cnt    <= '0;
          r_idx    <= w_word[idx_w_lp-1:0];
          r_err    <= w_req_err;
          r_wrap   <= w_wrap_ok;
        end
        WDATA: if (w_w_hs) begin
          r_idx <= w_idx_nxt;
          r_cnt <= r_cnt + 8'd1;
          if (w_wlast_bad) r_err   <= 1'b1;
          if (w_last_beat) r_state <= WRESP;
        end
        WRESP: if (s_axi_bready_i) r_state <= IDLE;
        RDATA: if (s_axi_rready_i) begin
          r_idx <= w_idx_nxt;
          r_cnt <= r_cnt + 8'd1;
          if (w_last_beat) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  logic w_unused;
  assign w_unused = ^{s_axi_awcache_i, s_axi_awprot_i, s_axi_awqos_i,
                      s_axi_arcache_i, s_axi_arprot_i, s_axi_arqos_i, s_axi_wid_i};

endmodule
